// File: rtl/button_press_conditioner_if.sv
// rtl/button_press_conditioner_if.sv - button inputs and press outputs; press_count exists only with BTN_PRESS_CNT_EN
interface button_press_conditioner_if;
  logic [2:0]  btn_raw;
  logic [2:0]  press_pulse;
  logic [2:0]  btn_level;
  logic        busy;
`ifdef BTN_PRESS_CNT_EN
  logic [15:0] press_count;

  modport master (
    input  btn_raw,
    output press_pulse,
    output btn_level,
    output busy,
    output press_count
  );

  modport slave (
    output btn_raw,
    input  press_pulse,
    input  btn_level,
    input  busy,
    input  press_count
  );
`else
  modport master (
    input  btn_raw,
    output press_pulse,
    output btn_level,
    output busy
  );

  modport slave (
    output btn_raw,
    input  press_pulse,
    input  btn_level,
    input  busy
  );
`endif
endinterface

// File: rtl/button_press_conditioner.sv
// rtl/button_press_conditioner.sv - sync, debounce and one-pulse-per-press gating of three buttons; BTN_PRESS_CNT_EN adds press_count
module button_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 200,
  parameter int CNT_W           = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  button_press_conditioner_if.master bus
);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       s1_q;
  logic [2:0]       s2_q;
  logic [2:0]       level_q;
  logic [2:0]       level_d;
  logic [2:0]       level_dly_q;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [2:0]       rise;
  state_t           state_q;
  state_t           state_d;
  logic [2:0]       pulse_q;
  logic [2:0]       pulse_d;

  // Two-flop synchroniser for the asynchronous raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.btn_raw;
      s2_q <= s1_q;
    end
  end

  // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounced levels, their one-cycle delay and the per-bit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q     <= '0;
      level_dly_q <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_q;
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rise = level_q & ~level_dly_q;

  // Accept the lowest-index rise when idle, then ignore everything until all buttons are released
  always_comb begin
    state_d = state_q;
    pulse_d = '0;
    case (state_q)
      IDLE: begin
        if (rise != 3'b000) begin
          state_d = HELD;
          if (rise[0]) begin
            pulse_d = 3'b001;
          end else if (rise[1]) begin
            pulse_d = 3'b010;
          end else begin
            pulse_d = 3'b100;
          end
        end
      end
      HELD: begin
        if (level_q == 3'b000) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered press pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pulse_q <= '0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

  assign bus.press_pulse = pulse_q;
  assign bus.btn_level   = level_q;
  assign bus.busy        = (state_q == HELD);

`ifdef BTN_PRESS_CNT_EN
  logic        accept;
  logic [15:0] press_count_q;

  assign accept = (state_q == IDLE) && (rise != 3'b000);

  // Saturating count of accepted presses, stepping with the pulse register
  always_ff @(posedge clk) begin
    if (rst) begin
      press_count_q <= '0;
    end else if (accept && (press_count_q != 16'hFFFF)) begin
      press_count_q <= press_count_q + 16'd1;
    end
  end

  assign bus.press_count = press_count_q;
`else
`endif

endmodule

// File: tb/tb_button_press_conditioner.sv
// tb/tb_button_press_conditioner.sv - directed and randomized checks of button_press_conditioner
module tb_button_press_conditioner;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  button_press_conditioner_if bus ();

  button_press_conditioner #(
    .DEBOUNCE_CYCLES(N),
    .CNT_W          (16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Reference model: debounce as "last N synchronised samples all disagree"
  logic [2:0] hist[$];
  logic [2:0] samp[$];
  logic [2:0] m_level      = 3'b000;
  logic [2:0] m_level_prev = 3'b000;
  logic [2:0] m_pulse      = 3'b000;
  logic       m_held       = 1'b0;
  int         m_count      = 0;

  always @(posedge clk) begin
    logic [2:0] s;
    logic [2:0] m_rise;
    logic [2:0] nl;
    bit         all_diff;
    if (rst) begin
      hist.delete();
      samp.delete();
      m_level      = 3'b000;
      m_level_prev = 3'b000;
      m_pulse      = 3'b000;
      m_held       = 1'b0;
      m_count      = 0;
    end else begin
      s = (hist.size() >= 2) ? hist[hist.size()-2] : 3'b000;
      hist.push_back(bus.btn_raw);
      if (hist.size() > 2) void'(hist.pop_front());
      samp.push_back(s);
      if (samp.size() > N) void'(samp.pop_front());
      nl = m_level;
      for (int b = 0; b < 3; b++) begin
        all_diff = (samp.size() == N);
        foreach (samp[k]) if (samp[k][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) nl[b] = ~m_level[b];
      end
      m_rise  = m_level & ~m_level_prev;
      m_pulse = 3'b000;
      if (!m_held) begin
        if (m_rise != 3'b000) begin
          if (m_rise[0]) m_pulse = 3'b001;
          else if (m_rise[1]) m_pulse = 3'b010;
          else m_pulse = 3'b100;
          m_held = 1'b1;
          if (m_count < 65535) m_count++;
        end
      end else if (m_level == 3'b000) begin
        m_held = 1'b0;
      end
      m_level_prev = m_level;
      m_level      = nl;
    end
  end

  task automatic cyc(input logic [2:0] raw);
    bus.btn_raw = raw;
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (N + 8) cyc(3'b000);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.btn_raw = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.press_pulse !== 3'b000) begin
      failures++;
      $display("FAIL reset_pulse got=%b exp=000", bus.press_pulse);
    end
    checks++;
    if (bus.btn_level !== 3'b000) begin
      failures++;
      $display("FAIL reset_level got=%b exp=000", bus.btn_level);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
`ifdef BTN_PRESS_CNT_EN
    checks++;
    if (bus.press_count !== 16'h0000) begin
      failures++;
      $display("FAIL reset_count got=%h exp=0000", bus.press_count);
    end
`endif
    rst = 1'b0;
    settle();
  endtask

  task automatic test_clean_press();
    int first  = -1;
    int npulse = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(3'b001);
      if (bus.press_pulse !== 3'b000) begin
        npulse++;
        if (first < 0) first = i;
        checks++;
        if (bus.press_pulse !== 3'b001) begin
          failures++;
          $display("FAIL clean_pulse_val edge=%0d got=%b exp=001", i, bus.press_pulse);
        end
      end
      checks++;
      if (bus.busy !== (i >= 6)) begin
        failures++;
        $display("FAIL clean_busy edge=%0d got=%b exp=%b", i, bus.busy, (i >= 6));
      end
    end
    checks++;
    if (first !== 6) begin
      failures++;
      $display("FAIL clean_pulse_edge got=%0d exp=6", first);
    end
    checks++;
    if (npulse !== 1) begin
      failures++;
      $display("FAIL clean_pulse_count got=%0d exp=1", npulse);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(3'b000);
      checks++;
      if (bus.busy !== (i < 6)) begin
        failures++;
        $display("FAIL release_busy edge=%0d got=%b exp=%b", i, bus.busy, (i < 6));
      end
    end
  endtask

  task automatic test_glitch();
    logic [2:0] pat [7];
    pat = '{3'b010, 3'b010, 3'b010, 3'b000, 3'b010, 3'b010, 3'b010};
    for (int i = 0; i < 19; i++) begin
      cyc((i < 7) ? pat[i] : 3'b000);
      checks++;
      if (bus.btn_level[1] !== 1'b0 || bus.press_pulse !== 3'b000) begin
        failures++;
        $display("FAIL glitch edge=%0d level=%b pulse=%b exp level[1]=0 pulse=000",
                 i, bus.btn_level, bus.press_pulse);
      end
    end
  endtask

  task automatic test_simultaneous();
    int first  = -1;
    int npulse = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(3'b110);
      if (bus.press_pulse !== 3'b000) begin
        npulse++;
        if (first < 0) first = i;
        checks++;
        if (bus.press_pulse !== 3'b010) begin
          failures++;
          $display("FAIL simul_pulse_val edge=%0d got=%b exp=010", i, bus.press_pulse);
        end
      end
    end
    checks++;
    if (first !== 6 || npulse !== 1) begin
      failures++;
      $display("FAIL simul_pulse first=%0d count=%0d exp first=6 count=1", first, npulse);
    end
    settle();
  endtask

  task automatic test_held_block();
    int first  = -1;
    int npulse = 0;
    repeat (10) cyc(3'b001);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL held_busy got=%b exp=1", bus.busy);
    end
    for (int i = 0; i < 12; i++) begin
      cyc(3'b101);
      checks++;
      if (bus.press_pulse !== 3'b000) begin
        failures++;
        $display("FAIL held_block edge=%0d got=%b exp=000", i, bus.press_pulse);
      end
    end
    settle();
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL held_idle got=%b exp=0", bus.busy);
    end
    for (int i = 0; i < 20; i++) begin
      cyc(3'b100);
      if (bus.press_pulse !== 3'b000) begin
        npulse++;
        if (first < 0) first = i;
        checks++;
        if (bus.press_pulse !== 3'b100) begin
          failures++;
          $display("FAIL held_new_val edge=%0d got=%b exp=100", i, bus.press_pulse);
        end
      end
    end
    checks++;
    if (first !== 6 || npulse !== 1) begin
      failures++;
      $display("FAIL held_new_pulse first=%0d count=%0d exp first=6 count=1", first, npulse);
    end
    settle();
  endtask

  task automatic test_reset_mid();
    int first  = -1;
    int npulse = 0;
    for (int i = 0; i < 25; i++) begin
      rst = (i == 5);
      cyc(3'b001);
      if (bus.press_pulse !== 3'b000) begin
        npulse++;
        if (first < 0) first = i;
        checks++;
        if (bus.press_pulse !== 3'b001) begin
          failures++;
          $display("FAIL rstmid_val edge=%0d got=%b exp=001", i, bus.press_pulse);
        end
      end
    end
    rst = 1'b0;
    checks++;
    if (first !== 12 || npulse !== 1) begin
      failures++;
      $display("FAIL rstmid_pulse first=%0d count=%0d exp first=12 count=1", first, npulse);
    end
    settle();
  endtask

  task automatic test_random();
    logic [2:0] raw  = 3'b000;
    int         hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        raw  = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 10);
      end
      hold--;
      rst = ($urandom_range(0, 299) == 0);
      cyc(raw);
      checks++;
      if (bus.press_pulse !== m_pulse) begin
        failures++;
        $display("FAIL rand_pulse cyc=%0d got=%b exp=%b", i, bus.press_pulse, m_pulse);
      end
      checks++;
      if (bus.btn_level !== m_level) begin
        failures++;
        $display("FAIL rand_level cyc=%0d got=%b exp=%b", i, bus.btn_level, m_level);
      end
      checks++;
      if (bus.busy !== m_held) begin
        failures++;
        $display("FAIL rand_busy cyc=%0d got=%b exp=%b", i, bus.busy, m_held);
      end
      checks++;
      if ($countones(bus.press_pulse) > 1) begin
        failures++;
        $display("FAIL rand_onehot cyc=%0d got=%b exp=at most one bit", i, bus.press_pulse);
      end
`ifdef BTN_PRESS_CNT_EN
      checks++;
      if (bus.press_count !== 16'(m_count)) begin
        failures++;
        $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", i, bus.press_count, m_count);
      end
`endif
    end
    rst = 1'b0;
    settle();
  endtask

`ifdef BTN_PRESS_CNT_EN
  task automatic test_count();
    rst = 1'b1;
    cyc(3'b000);
    rst = 1'b0;
    for (int p = 0; p < 5; p++) begin
      repeat (10) cyc(3'b001);
      settle();
    end
    checks++;
    if (bus.press_count !== 16'd5) begin
      failures++;
      $display("FAIL count_five got=%0d exp=5", bus.press_count);
    end
    force dut.press_count_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.press_count_q;
    for (int p = 0; p < 3; p++) begin
      repeat (10) cyc(3'b010);
      settle();
      checks++;
      if (bus.press_count !== 16'hFFFF) begin
        failures++;
        $display("FAIL count_sat press=%0d got=%h exp=ffff", p, bus.press_count);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.btn_raw = 3'b000;
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_held_block();
    test_reset_mid();
    test_random();
`ifdef BTN_PRESS_CNT_EN
    test_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_press_conditioner.md
Name: button_press_conditioner

Overview:
- Upstream front end for the three-button sequence recorder/player FSM.
- Synchronises and debounces the three raw pushbuttons.
- Emits at most one single-cycle, one-hot press pulse per physical press; these pulses drive the FSM's in1/in2/in3 inputs.
- Blocks further presses until every button is stably released, so one press can never advance the downstream FSM twice.

Parameters:
- DEBOUNCE_CYCLES, 200: consecutive cycles a synchronised input must differ from its stable level before that level flips. Legal range 2..2^CNT_W-1.
- CNT_W, 16: width of each debounce counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- btn_raw  in  3  asynchronous raw buttons, active-high; bit0→in1, bit1→in2, bit2→in3.
- press_pulse  out  3  one-hot, single-cycle accepted-press pulse; bit n drives the downstream in(n+1).
- btn_level  out  3  debounced stable level of each button.
- busy  out  1  high while an accepted press is awaiting full release (FSM state HELD).
- press_count  out  16  saturating count of accepted presses; present only with BTN_PRESS_CNT_EN.

Behaviour:
- Reset (rst high at a clk edge): sync stages, btn_level, debounce counters, press_pulse, busy and press_count all clear to 0; FSM enters IDLE.
- Synchroniser, per bit: s1 <= btn_raw, then s2 <= s1 (two flops).
- Debounce, per bit, counter cnt:
  - If s2 == btn_level: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: btn_level <= s2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - Any glitch back to the stable value restarts the count.
- Press detect: rise[n] = btn_level[n] & ~btn_level_d[n], where btn_level_d is btn_level delayed one cycle.
- FSM states: IDLE, HELD.
  - IDLE: if any rise, accept the lowest-index rising bit (in1 > in2 > in3, the same priority the downstream FSM uses). press_pulse <= one-hot of that bit for one cycle; go to HELD. Other bits rising in the same cycle are discarded.
  - HELD: busy=1; press_pulse=0. Rises on any bit are ignored. When btn_level == 3'b000, go to IDLE; busy is 0 from the next cycle.
- press_pulse is registered and never has more than one bit set. It is 0 on every cycle except the one cycle following acceptance.
- Latency: raw sampled high at edge 0 and held → s2 high at edge 1 → btn_level high at edge N+1 → press_pulse high after edge N+2 for exactly one cycle (N = DEBOUNCE_CYCLES).
- Release latency: btn_level falls at edge M+N+1 when raw is first sampled low at edge M. The FSM returns to IDLE on the edge after all levels are low.
- Held through reset: the button is treated as a new press. After reset deasserts, the pulse appears N+2 edges later. Downstream sees this as a normal press.
- Reset mid-debounce or mid-HELD: all state is abandoned immediately with no pulse. Partial counts are lost.
- Counter widths: cnt compares against DEBOUNCE_CYCLES-1 at CNT_W bits. Wrap is impossible because cnt clears before exceeding the limit.

Optional Feature:
- Macro: BTN_PRESS_CNT_EN.
- Defined: press_count port exists. It increments by 1 on every accepted press (the same cycle press_pulse is set), saturates at 16'hFFFF and clears on rst.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- DEBOUNCE_CYCLES=4; raw bit0 rises at edge 0 and holds 20 cycles → press_pulse=3'b001 only in the cycle after edge 6; busy=1 from edge 6 until release completes.
- DEBOUNCE_CYCLES=4; bit1 toggles high 3 cycles, low 1, high 3, low → btn_level stays 0 and press_pulse never asserts.
- DEBOUNCE_CYCLES=4; bits 1 and 2 rise on the same edge → press_pulse=3'b010 once; bit2 never pulses, even while bit1 is still held.
- Hold bit0, then while in HELD press bit2 cleanly → no pulse for bit2. After both are released, a new bit2 press → press_pulse=3'b100.
- Assert rst for 1 cycle at edge 5 of a bit0 press with N=4 → no pulse from that count. With raw still high, press_pulse=3'b001 appears N+2 edges after reset deasserts.
- With BTN_PRESS_CNT_EN: 5 clean presses → press_count=5. Force the count to 16'hFFFE, then 3 presses → 16'hFFFF.
